// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception arbitration stage:
//   - encoded exception types handed to CP0
//   - CP0 register addresses seen on the WB write port
//   - bit positions inside except_flags_i
//   - controller state encoding
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_INVALID = 32'ha;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_ERET    = 32'he;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int F_SYSCALL = 0;
  localparam int F_INVALID = 1;
  localparam int F_TRAP    = 2;
  localparam int F_OV      = 3;
  localparam int F_ERET    = 4;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM/WB/CP0 side signals of the exception stage.
//   slave  : exc_ctrl itself (consumes pipeline/CP0 state, drives results)
//   master : whoever feeds the stage (pipeline model / testbench)
interface exc_ctrl_if;
  logic [5:0]  int_raw_i;
  logic        timer_int_i;
  logic        inst_valid_i;
  logic [4:0]  except_flags_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [5:0]  int_o;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  int_raw_i, timer_int_i, inst_valid_i, except_flags_i,
           current_inst_addr_i, is_in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output int_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           flush_o, new_pc_o
  );

  modport master (
    output int_raw_i, timer_int_i, inst_valid_i, except_flags_i,
           current_inst_addr_i, is_in_delayslot_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  int_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
           flush_o, new_pc_o
  );
endinterface

// File: rtl/exc_ctrl_int_sync.sv
// Multi-bit flop-chain synchronizer.
//   clk, rst (async, active low)
//   d : asynchronous input bits
//   q : d delayed by STAGES clock edges
module exc_ctrl_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception arbitration between MEM and CP0.
//   clk, rst (async, active low)
//   bus : exc_ctrl_if.slave -- raw flags/PC/delay-slot of the MEM instruction,
//         external interrupts, CP0 Status/Cause/EPC plus the WB CP0 write port;
//         produces excepttype, synced interrupt lines, flush and redirect PC.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.slave  bus
);

  // The last synchronizer stage lives here so the timer can be OR'd in
  // and registered with it: raw lines see SYNC_STAGES edges, timer sees one.
  logic [5:0] int_mid, int_q;

  exc_ctrl_int_sync #(.WIDTH(6), .STAGES(SYNC_STAGES-1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.int_raw_i),
    .q   (int_mid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) int_q <= '0;
    else      int_q <= {int_mid[5] | bus.timer_int_i, int_mid[4:0]};
  end

  // CP0 values as they will be after this cycle's WB write.
  logic [31:0] status_f, cause_f, epc_f;

  always_comb begin
    status_f = bus.cp0_status_i;
    cause_f  = bus.cp0_cause_i;
    epc_f    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      case (bus.wb_cp0_waddr_i)
        CP0_STATUS: status_f = bus.wb_cp0_data_i;
        CP0_EPC:    epc_f    = bus.wb_cp0_data_i;
        CP0_CAUSE: begin
          // only software-writable Cause fields are forwarded
          cause_f[9:8] = bus.wb_cp0_data_i[9:8];
          cause_f[22]  = bus.wb_cp0_data_i[22];
          cause_f[23]  = bus.wb_cp0_data_i[23];
        end
        default: ;
      endcase
    end
  end

  logic        pending;
  logic [31:0] code;

  assign pending = (({int_q, cause_f[9:8]} & status_f[15:8]) != 8'h0) &&
                   !status_f[1] && status_f[0] && bus.inst_valid_i;

  always_comb begin
    code = EXC_NONE;
    if (bus.inst_valid_i) begin
      if      (pending)                      code = EXC_INT;
      else if (bus.except_flags_i[F_SYSCALL]) code = EXC_SYSCALL;
      else if (bus.except_flags_i[F_INVALID]) code = EXC_INVALID;
      else if (bus.except_flags_i[F_TRAP])    code = EXC_TRAP;
      else if (bus.except_flags_i[F_OV])      code = EXC_OV;
      else if (bus.except_flags_i[F_ERET])    code = EXC_ERET;
    end
  end

  state_e      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] tgt, tgt_n;
  logic [31:0] exc_type, new_pc;
  logic        flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      tgt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tgt   <= tgt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tgt_n    = tgt;
    exc_type = EXC_NONE;
    flush    = 1'b0;
    new_pc   = '0;
    case (state)
      IDLE: begin
        exc_type = code;
        if (code != EXC_NONE) begin
          flush  = 1'b1;
          new_pc = (code == EXC_ERET) ? epc_f : EXC_VECTOR;
          tgt_n  = new_pc;
          if (FLUSH_CYCLES > 1) begin
            state_n = HOLD;
            cnt_n   = 4'(FLUSH_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        // flags seen here belong to squashed instructions; they come back later
        flush  = 1'b1;
        new_pc = tgt;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.int_o               = int_q;
  assign bus.excepttype_o        = exc_type;
  assign bus.flush_o             = flush;
  assign bus.new_pc_o            = new_pc;
  assign bus.current_inst_addr_o = bus.current_inst_addr_i;
  assign bus.is_in_delayslot_o   = bus.is_in_delayslot_i;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  localparam int          FLUSH_CYCLES = 2;
  localparam int          SYNC_STAGES  = 2;
  localparam logic [31:0] VEC          = 32'h0000_0040;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  exc_ctrl_if ifc ();

  exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FLUSH_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [5:0]  raw_hist [SYNC_STAGES-1]; // raw lines sampled at past edges
  logic [5:0]  int_m;
  int          hold_left;
  logic [31:0] tgt_m;
  logic [31:0] m_code, m_pc;

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES-1; i++) raw_hist[i] = '0;
    int_m     = '0;
    hold_left = 0;
    tgt_m     = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluate the spec rules on the current inputs and compare all outputs.
  task automatic settle();
    logic [31:0] st, ca, ep, code, pc;
    logic        pend;
    #2;
    st = ifc.cp0_status_i; ca = ifc.cp0_cause_i; ep = ifc.cp0_epc_i;
    if (ifc.wb_cp0_we_i && ifc.wb_cp0_waddr_i == 5'd12) st = ifc.wb_cp0_data_i;
    if (ifc.wb_cp0_we_i && ifc.wb_cp0_waddr_i == 5'd14) ep = ifc.wb_cp0_data_i;
    if (ifc.wb_cp0_we_i && ifc.wb_cp0_waddr_i == 5'd13) begin
      ca[9:8] = ifc.wb_cp0_data_i[9:8];
      ca[22]  = ifc.wb_cp0_data_i[22];
      ca[23]  = ifc.wb_cp0_data_i[23];
    end
    pend = (({int_m, ca[9:8]} & st[15:8]) != 0) && !st[1] && st[0];
    code = 0;
    if (ifc.inst_valid_i) begin
      if      (pend)                  code = 32'h1;
      else if (ifc.except_flags_i[0]) code = 32'h8;
      else if (ifc.except_flags_i[1]) code = 32'ha;
      else if (ifc.except_flags_i[2]) code = 32'hd;
      else if (ifc.except_flags_i[3]) code = 32'hc;
      else if (ifc.except_flags_i[4]) code = 32'he;
    end
    pc = (code == 32'he) ? ep : VEC;
    if (hold_left > 0) begin
      chk("exc_hold",   ifc.excepttype_o, 0);
      chk("flush_hold", ifc.flush_o, 1);
      chk("pc_hold",    ifc.new_pc_o, tgt_m);
      m_code = 0;
    end else begin
      chk("exc",   ifc.excepttype_o, code);
      chk("flush", ifc.flush_o, code != 0);
      chk("pc",    ifc.new_pc_o, (code != 0) ? pc : 0);
      m_code = code;
    end
    m_pc = pc;
    chk("int_o", ifc.int_o, int_m);
    chk("pc_pass", ifc.current_inst_addr_o, ifc.current_inst_addr_i);
    chk("ds_pass", ifc.is_in_delayslot_o, ifc.is_in_delayslot_i);
  endtask

  task automatic tick();
    @(posedge clk);
    if (hold_left > 0) hold_left--;
    else if (m_code != 0) begin
      tgt_m     = m_pc;
      hold_left = FLUSH_CYCLES - 1;
    end
    int_m = {raw_hist[SYNC_STAGES-2][5] | ifc.timer_int_i, raw_hist[SYNC_STAGES-2][4:0]};
    for (int i = SYNC_STAGES-2; i > 0; i--) raw_hist[i] = raw_hist[i-1];
    raw_hist[0] = ifc.int_raw_i;
    #1;
  endtask

  task automatic quiet();
    ifc.inst_valid_i = 0; ifc.except_flags_i = 0; ifc.wb_cp0_we_i = 0;
    ifc.timer_int_i = 0;
  endtask

  initial begin
    rst = 0;
    ifc.int_raw_i = 0; ifc.timer_int_i = 0; ifc.inst_valid_i = 0;
    ifc.except_flags_i = 0; ifc.current_inst_addr_i = 0; ifc.is_in_delayslot_i = 0;
    ifc.cp0_status_i = 0; ifc.cp0_cause_i = 0; ifc.cp0_epc_i = 0;
    ifc.wb_cp0_we_i = 0; ifc.wb_cp0_waddr_i = 0; ifc.wb_cp0_data_i = 0;
    model_reset();
    #2;
    chk("rst_int",   ifc.int_o, 0);
    chk("rst_flush", ifc.flush_o, 0);
    chk("rst_pc",    ifc.new_pc_o, 0);
    chk("rst_exc",   ifc.excepttype_o, 0);
    #10 rst = 1;

    // sync latency: line 0 visible after exactly two edges
    ifc.int_raw_i = 6'b000001;
    settle(); chk("sync0", ifc.int_o, 0); tick();
    settle(); chk("sync1", ifc.int_o, 0); tick();
    settle(); chk("sync2", ifc.int_o, 6'b000001); chk("sync_flush", ifc.flush_o, 0); tick();

    // interrupt taken, two flush cycles
    ifc.cp0_status_i = 32'h0000_0401; ifc.inst_valid_i = 1; ifc.current_inst_addr_i = 32'h100;
    settle(); chk("int_exc", ifc.excepttype_o, 32'h1); chk("int_pc0", ifc.new_pc_o, 32'h40); tick();
    settle(); chk("int_hold_exc", ifc.excepttype_o, 0); chk("int_pc1", ifc.new_pc_o, 32'h40);
    chk("int_flush1", ifc.flush_o, 1); tick();
    quiet(); ifc.cp0_status_i = 0;
    settle(); tick();
    settle(); tick();

    // syscall + overflow: syscall wins
    ifc.inst_valid_i = 1; ifc.except_flags_i = 5'b01001; ifc.current_inst_addr_i = 32'h200;
    settle(); chk("sys_exc", ifc.excepttype_o, 32'h8); chk("sys_pc", ifc.new_pc_o, 32'h40); tick();
    quiet(); settle(); tick(); settle(); tick();

    // eret with EPC forwarded from WB
    ifc.inst_valid_i = 1; ifc.except_flags_i = 5'b10000; ifc.cp0_epc_i = 32'h300;
    ifc.wb_cp0_we_i = 1; ifc.wb_cp0_waddr_i = 5'd14; ifc.wb_cp0_data_i = 32'h380;
    settle(); chk("eret_exc", ifc.excepttype_o, 32'he); chk("eret_pc", ifc.new_pc_o, 32'h380); tick();
    quiet(); settle(); chk("eret_pc_hold", ifc.new_pc_o, 32'h380); tick(); settle(); tick();

    // pending interrupt masked by same-cycle Status write
    ifc.cp0_status_i = 32'h0000_0401; ifc.inst_valid_i = 1;
    ifc.wb_cp0_we_i = 1; ifc.wb_cp0_waddr_i = 5'd12; ifc.wb_cp0_data_i = 32'h0000_0400;
    settle(); chk("fwd_exc", ifc.excepttype_o, 0); chk("fwd_flush", ifc.flush_o, 0); tick();
    quiet(); ifc.cp0_status_i = 0;
    settle(); tick();

    // trap, then reset mid-HOLD
    ifc.inst_valid_i = 1; ifc.except_flags_i = 5'b00100;
    settle(); chk("trap_exc", ifc.excepttype_o, 32'hd); tick();
    quiet();
    chk("trap_hold", ifc.flush_o, 1);
    rst = 0; #1;
    chk("arst_flush", ifc.flush_o, 0);
    chk("arst_int",   ifc.int_o, 0);
    chk("arst_pc",    ifc.new_pc_o, 0);
    model_reset();
    rst = 1;
    ifc.inst_valid_i = 1; ifc.except_flags_i = 5'b00010;
    settle(); chk("inv_exc", ifc.excepttype_o, 32'ha); tick();
    quiet(); settle(); tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) ifc.int_raw_i = 6'($urandom);
      ifc.timer_int_i  = ($urandom_range(0, 7) == 0);
      ifc.inst_valid_i = ($urandom_range(0, 3) != 0);
      ifc.except_flags_i = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      ifc.current_inst_addr_i = $urandom;
      ifc.is_in_delayslot_i   = 1'($urandom);
      case ($urandom_range(0, 4))
        0: ifc.cp0_status_i = 32'h0000_ff01;
        1: ifc.cp0_status_i = 32'h0000_0401;
        2: ifc.cp0_status_i = 32'h0000_ff03;
        3: ifc.cp0_status_i = 32'h0;
        default: ifc.cp0_status_i = $urandom;
      endcase
      ifc.cp0_cause_i    = $urandom;
      ifc.cp0_epc_i      = $urandom;
      ifc.wb_cp0_we_i    = ($urandom_range(0, 3) == 0);
      ifc.wb_cp0_waddr_i = 5'($urandom_range(11, 15));
      ifc.wb_cp0_data_i  = $urandom;
      settle(); tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception arbitration stage between the MEM pipeline stage and the CP0 register file.
- Takes the raw exception flags, PC and delay-slot flag of the instruction in MEM, plus the six external interrupt lines.
- Uses CP0 Status/Cause/EPC, forwarded through a same-cycle WB write to CP0, to produce one encoded exception type for CP0.
- Produces a multi-cycle pipeline flush with the redirect PC, and supplies synchronized interrupt lines to CP0 Cause.IP[7:2].

Parameters:
- EXC_VECTOR, 32'h00000040, redirect PC for every exception except eret.
- FLUSH_CYCLES, 2, total cycles flush_o stays high per taken exception (legal range 1..15).
- SYNC_STAGES, 2, synchronizer depth for int_raw_i (legal range 2..3).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active low (0 = reset)
- int_raw_i  in  6  asynchronous external interrupt lines
- timer_int_i  in  1  CP0 timer interrupt, synchronous to clk
- inst_valid_i  in  1  MEM holds a real (non-bubble) instruction
- except_flags_i  in  5  [0] syscall, [1] invalid inst, [2] trap, [3] overflow, [4] eret
- current_inst_addr_i  in  32  PC of the MEM instruction
- is_in_delayslot_i  in  1  MEM instruction sits in a branch delay slot
- cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  registered CP0 values
- wb_cp0_we_i  in  1  WB stage writes CP0 this cycle
- wb_cp0_waddr_i  in  5  WB CP0 write address (12 Status, 13 Cause, 14 EPC)
- wb_cp0_data_i  in  32  WB CP0 write data
- int_o  out  6  synchronized interrupt lines to CP0 int_i
- excepttype_o  out  32  encoded exception type to CP0
- current_inst_addr_o  out  32  pass-through to CP0
- is_in_delayslot_o  out  1  pass-through to CP0
- flush_o  out  1  squash all pipeline stages and redirect the PC
- new_pc_o  out  32  redirect target, valid while flush_o = 1

Behaviour:
- Reset (rst = 0, asynchronous): all sync flops 0, state IDLE, hold counter 0, stored PC 0. Outputs: int_o = 0, flush_o = 0, new_pc_o = 0, excepttype_o = 0.
- Interrupt sync: int_raw_i passes through a SYNC_STAGES flop chain, giving 2 clk edges of latency by default.
  - int_o[4:0] = synced bits [4:0].
  - int_o[5] = synced bit 5 OR timer_int_i (registered together with the sync output, 1 cycle latency for the timer).
- Forwarding: if wb_cp0_we_i = 1 and the address matches, status_f / epc_f = wb_cp0_data_i.
  - For Cause, only bits [9:8], 22 and 23 come from WB data; all other Cause bits come from cp0_cause_i.
  - Without a matching write, status_f, cause_f and epc_f equal the CP0 inputs.
- Interrupt pending condition:
  - pending = ({int_o, cause_f[9:8]} & status_f[15:8]) != 0
  - and status_f[1] (EXL) = 0
  - and status_f[0] (IE) = 1
  - and inst_valid_i = 1.
- Encoding in state IDLE (combinational, fixed priority), first match wins:
  - pending → 32'h1
  - syscall → 32'h8
  - invalid inst → 32'ha
  - trap → 32'hd
  - overflow → 32'hc
  - eret → 32'he
  - otherwise 0.
  - When inst_valid_i = 0, all flags are ignored and the result is 0.
- A taken exception is any nonzero excepttype_o in IDLE.
- Taken exception in cycle N:
  - flush_o = 1 combinationally in cycle N.
  - new_pc_o = epc_f for eret, EXC_VECTOR otherwise.
  - The target is latched at edge N.
  - If FLUSH_CYCLES > 1, state moves to HOLD with counter = FLUSH_CYCLES-1.
- State HOLD:
  - flush_o = 1 and new_pc_o = latched target.
  - excepttype_o forced to 0; new flags are dropped, because the squashed instruction re-enters later.
  - Counter decrements each cycle; at 1 the state goes to IDLE.
- Back-to-back: an exception presented in the first IDLE cycle after HOLD is taken normally.
- Pass-throughs current_inst_addr_o and is_in_delayslot_o are combinational and never gated.
- Reset during HOLD: immediate return to IDLE, flush_o drops asynchronously.
- Simultaneous WB write to Status (clearing IE) and a pending interrupt: the forwarded value wins, so no interrupt is taken.

Decomposition:
- Shared package/def header holds:
  - exception codes EXC_INT = 32'h1, EXC_SYSCALL = 32'h8, EXC_INVALID = 32'ha, EXC_TRAP = 32'hd, EXC_OV = 32'hc, EXC_ERET = 32'he
  - CP0 addresses 12/13/14 and except_flags_i bit indices
  - state encoding IDLE/HOLD.
- One sub-module is natural: int_sync, a parameterized multi-bit N-flop synchronizer with async active-low reset.

Test Plan:
- Reset release, int_raw_i = 6'b000001 at cycle 0 → int_o = 6'b000001 after exactly 2 edges; flush_o stays 0.
- Status = 32'h0000_0401 (IM2, IE), int_raw_i[0] = 1, inst_valid_i = 1, PC = 32'h100 → excepttype_o = 32'h1, flush_o high 2 cycles, new_pc_o = 32'h40 both cycles; excepttype_o = 0 in cycle 2.
- syscall and overflow flags together, PC = 32'h200 → excepttype_o = 32'h8, new_pc_o = 32'h40.
- eret flag, cp0_epc_i = 32'h300, WB writes EPC = 32'h380 the same cycle → excepttype_o = 32'he, new_pc_o = 32'h380.
- Interrupt pending, WB writes Status = 32'h0000_0400 the same cycle → excepttype_o = 0, flush_o = 0.
- Trap taken, rst pulsed low in the HOLD cycle → flush_o = 0 immediately; after release an invalid-inst flag → excepttype_o = 32'ha.
